// File: rtl/hit_capture.sv
// Comparator hit capture: synchronise, edge-detect and accumulate a per-channel hit mask
// around each accepted trigger. HIT_MULTIPLICITY_EN adds a popcount of the captured mask.
module hit_capture #(
    parameter int N_CH        = 24,
    parameter int SYNC_STAGES = 2,
    parameter int WINDOW      = 8,
    parameter int LOOKBACK    = 4
) (
    input  logic            sampling_clk,
    input  logic            reset,
    input  logic [N_CH-1:0] c_input_async,
    input  logic [N_CH-1:0] channel_mask,
    input  logic            trig_pulse,
    output logic [N_CH-1:0] hit_data,
    output logic            hit_valid,
    input  logic            hit_ack,
    output logic            busy,
    output logic            overflow,
    output logic [7:0]      drop_count,
    output logic [4:0]      hit_mult
);
    // state     | meaning
    // S_IDLE    | waiting for a trigger
    // S_COLLECT | merging post-trigger edges until the window count reaches 1
    // S_HOLD    | result presented, waiting for hit_ack
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    localparam int CNT_W = $clog2(WINDOW);

    state_t            state_q, state_nxt;
    logic [N_CH-1:0]   sync_q [SYNC_STAGES];
    logic [N_CH-1:0]   prev_q, edge_q, hist_or;
    logic [N_CH-1:0]   acc_q, acc_nxt, acc_merge;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              load_result, clr_valid, drop;

    // Edge is registered so input-to-edge latency is SYNC_STAGES+1.
    always_ff @(posedge sampling_clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= c_input_async;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q & channel_mask;
        end
    end

    generate
        if (LOOKBACK > 0) begin : g_hist
            logic [N_CH-1:0] hist_q [LOOKBACK];
            always_ff @(posedge sampling_clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < LOOKBACK; k++) hist_q[k] <= '0;
                end else begin
                    hist_q[0] <= edge_q;
                    for (int k = 1; k < LOOKBACK; k++) hist_q[k] <= hist_q[k-1];
                end
            end
            always_comb begin
                hist_or = '0;
                for (int k = 0; k < LOOKBACK; k++) hist_or = hist_or | hist_q[k];
            end
        end else begin : g_nohist
            assign hist_or = '0;
        end
    endgenerate

    assign acc_merge = acc_q | edge_q;

    always_ff @(posedge sampling_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            acc_q   <= acc_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        acc_nxt     = acc_q;
        cnt_nxt     = cnt_q;
        load_result = 1'b0;
        clr_valid   = 1'b0;
        drop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_pulse) begin
                    acc_nxt   = hist_or | edge_q;
                    cnt_nxt   = CNT_W'(WINDOW - 1);
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                acc_nxt = acc_merge;
                cnt_nxt = cnt_q - 1'b1;
                drop    = trig_pulse;
                if (cnt_q == CNT_W'(1)) begin
                    load_result = 1'b1;
                    state_nxt   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hit_ack) begin
                    clr_valid = 1'b1;
                    // A trigger coinciding with the ack starts the next window directly.
                    if (trig_pulse) begin
                        acc_nxt   = hist_or | edge_q;
                        cnt_nxt   = CNT_W'(WINDOW - 1);
                        state_nxt = S_COLLECT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    drop = trig_pulse;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sampling_clk or negedge reset) begin
        if (!reset) begin
            hit_data   <= '0;
            hit_valid  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (load_result) hit_data <= acc_merge;
            if (load_result)    hit_valid <= 1'b1;
            else if (clr_valid) hit_valid <= 1'b0;
            busy     <= (state_nxt != S_IDLE);
            overflow <= overflow | drop;
            if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
        end
    end

`ifdef HIT_MULTIPLICITY_EN
    always_ff @(posedge sampling_clk or negedge reset) begin
        if (!reset)           hit_mult <= '0;
        else if (load_result) hit_mult <= 5'($countones(acc_merge));
    end
`else
    assign hit_mult = '0;
`endif

endmodule

// File: tb/tb_hit_capture.sv
// Scoreboard bench for hit_capture: accepted triggers are queued by the stimulus side and
// a negedge monitor recomputes each window's hit mask from the recorded input history.
module tb_hit_capture;
    localparam int W   = 8;
    localparam int LB  = 4;
    localparam int LAT = 3;
    localparam int HMAX = 8192;

    logic        sampling_clk = 1'b0;
    logic        reset;
    logic [23:0] c_input_async, channel_mask;
    logic        trig_pulse, hit_ack;
    logic [23:0] hit_data;
    logic        hit_valid, busy, overflow;
    logic [7:0]  drop_count;
    logic [4:0]  hit_mult;

    always #5 sampling_clk = ~sampling_clk;

    hit_capture dut (
        .sampling_clk (sampling_clk),
        .reset        (reset),
        .c_input_async(c_input_async),
        .channel_mask (channel_mask),
        .trig_pulse   (trig_pulse),
        .hit_data     (hit_data),
        .hit_valid    (hit_valid),
        .hit_ack      (hit_ack),
        .busy         (busy),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .hit_mult     (hit_mult)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [23:0] in_hist   [HMAX];
    logic [23:0] mask_hist [HMAX];
    int   exp_q[$];
    // model phase: 0 idle, 1 collecting, 2 result held
    int   m_phase = 0, m_phase_n, m_T = 0, m_drops = 0, m_drops_n;
    logic m_ovf = 1'b0, m_ovf_n;
    logic prev_valid = 1'b0;
    logic [23:0] held_data = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] edge_vec(int c);
        logic [23:0] cur, old, msk;
        cur = (c - LAT >= 0)     ? in_hist[c-LAT]     : 24'h0;
        old = (c - LAT - 1 >= 0) ? in_hist[c-LAT-1]   : 24'h0;
        msk = (c - 1 >= 0)       ? mask_hist[c-1]     : 24'h0;
        return cur & ~old & msk;
    endfunction

    function automatic logic [23:0] window_mask(int t);
        logic [23:0] a;
        a = '0;
        for (int c = t - LB; c <= t + W - 1; c++)
            if (c >= 0) a = a | edge_vec(c);
        return a;
    endfunction

    function automatic logic [31:0] exp_mult(logic [23:0] m);
`ifdef HIT_MULTIPLICITY_EN
        return 32'($countones(m));
`else
        return 32'(m & 24'h0);
`endif
    endfunction

    task automatic accept();
        m_T = cyc;
        exp_q.push_back(cyc);
        m_phase_n = 1;
    endtask

    task automatic drop();
        m_ovf_n = 1'b1;
        if (m_drops < 255) m_drops_n = m_drops + 1;
    endtask

    task automatic tick();
        if (cyc < HMAX) begin
            in_hist[cyc]   = c_input_async;
            mask_hist[cyc] = channel_mask;
        end
        m_phase_n = m_phase;
        m_drops_n = m_drops;
        m_ovf_n   = m_ovf;
        case (m_phase)
            0: if (trig_pulse) accept();
            1: begin
                if (trig_pulse) drop();
                if (cyc == m_T + W - 1) m_phase_n = 2;
            end
            default: begin
                if (hit_ack) begin
                    if (trig_pulse) accept();
                    else            m_phase_n = 0;
                end else if (trig_pulse) drop();
            end
        endcase
        @(posedge sampling_clk);
        #1;
        cyc++;
        m_phase    = m_phase_n;
        m_drops    = m_drops_n;
        m_ovf      = m_ovf_n;
        trig_pulse = 1'b0;
        hit_ack    = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        c_input_async = '0;
        trig_pulse    = 1'b0;
        hit_ack       = 1'b0;
        #1;
        check("rst_hit_data",   32'(hit_data),   32'h0);
        check("rst_hit_valid",  32'(hit_valid),  32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_overflow",   32'(overflow),   32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);
        check("rst_hit_mult",   32'(hit_mult),   32'h0);
        exp_q.delete();
        m_phase = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
        repeat (2) @(posedge sampling_clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
    endtask

    always @(negedge sampling_clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            check("busy",       32'(busy),       32'(m_phase != 0));
            check("hit_valid",  32'(hit_valid),  32'(m_phase == 2));
            check("overflow",   32'(overflow),   32'(m_ovf));
            check("drop_count", 32'(drop_count), 32'(m_drops));
            if (hit_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid at cycle %0d: got hit_valid=1, expected no result pending", cyc);
                end else begin
                    int t;
                    t = exp_q.pop_front();
                    held_data = window_mask(t);
                    check("valid_cycle", 32'(cyc), 32'(t + W));
                    check("hit_data", 32'(hit_data), 32'(held_data));
                    check("hit_mult", 32'(hit_mult), exp_mult(held_data));
                end
            end else if (hit_valid) begin
                check("hit_data_hold", 32'(hit_data), 32'(held_data));
            end
            prev_valid = hit_valid;
        end
    end

    initial begin
        reset         = 1'b0;
        channel_mask  = 24'hFFFFFF;
        c_input_async = '0;
        trig_pulse    = 1'b0;
        hit_ack       = 1'b0;
        @(posedge sampling_clk);
        #1;

        // 1: lookback edge captured
        do_reset();
        c_input_async[3] = 1'b1;
        run_to(5);
        trig_pulse = 1'b1;
        tick();
        run_to(13);
        check("t1_valid", 32'(hit_valid), 32'h1);
        check("t1_data",  32'(hit_data),  32'h000008);
        hit_ack = 1'b1;
        tick();
        run_to(20);

        // 2: window end boundary, ch5 just outside
        do_reset();
        while (cyc < 18) begin
            if (cyc == 9)  c_input_async[0]  = 1'b1;
            if (cyc == 10) trig_pulse        = 1'b1;
            if (cyc == 14) c_input_async[23] = 1'b1;
            if (cyc == 15) c_input_async[5]  = 1'b1;
            tick();
        end
        check("t2_data", 32'(hit_data), 32'h800001);
`ifdef HIT_MULTIPLICITY_EN
        check("t2_mult", 32'(hit_mult), 32'd2);
`endif
        hit_ack = 1'b1;
        tick();

        // 3: masked channel gives an empty but valid result
        do_reset();
        channel_mask = 24'hFFFFFE;
        while (cyc < 13) begin
            if (cyc == 4) c_input_async[0] = 1'b1;
            if (cyc == 5) trig_pulse = 1'b1;
            tick();
        end
        check("t3_valid", 32'(hit_valid), 32'h1);
        check("t3_data",  32'(hit_data),  32'h0);
        hit_ack = 1'b1;
        tick();
        channel_mask = 24'hFFFFFF;

        // 4: drops in COLLECT and in HOLD
        do_reset();
        while (cyc < 17) begin
            if (cyc == 2) c_input_async[1] = 1'b1;
            if (cyc == 5 || cyc == 8 || cyc == 14) trig_pulse = 1'b1;
            tick();
        end
        check("t4_overflow",   32'(overflow),   32'h1);
        check("t4_drop_count", 32'(drop_count), 32'd2);
        check("t4_data",       32'(hit_data),   32'h000002);
        hit_ack = 1'b1;
        tick();

        // 5: ack and trigger together in HOLD
        do_reset();
        while (cyc < 13) begin
            if (cyc == 3) trig_pulse = 1'b1;
            if (cyc == 12) begin
                trig_pulse = 1'b1;
                hit_ack    = 1'b1;
            end
            tick();
        end
        check("t5_valid_low", 32'(hit_valid), 32'h0);
        check("t5_busy",      32'(busy),      32'h1);
        while (cyc < 20) begin
            if (cyc == 14) c_input_async[7] = 1'b1;
            tick();
        end
        check("t5_valid",      32'(hit_valid),  32'h1);
        check("t5_data",       32'(hit_data),   32'h000080);
        check("t5_drop_count", 32'(drop_count), 32'h0);
        hit_ack = 1'b1;
        tick();

        // 6: reset mid-COLLECT discards the window
        do_reset();
        while (cyc < 10) begin
            if (cyc == 1) c_input_async[2] = 1'b1;
            if (cyc == 5) trig_pulse = 1'b1;
            if (cyc == 6) c_input_async[9] = 1'b1;
            tick();
        end
        do_reset();
        while (cyc < 14) begin
            if (cyc == 2) c_input_async[11] = 1'b1;
            if (cyc == 6) trig_pulse = 1'b1;
            tick();
        end
        check("t6_data", 32'(hit_data), 32'h000800);
        hit_ack = 1'b1;
        tick();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            c_input_async = c_input_async ^ (24'($urandom) & 24'($urandom) & 24'($urandom) & 24'($urandom));
            if (i % 300 == 150) channel_mask = 24'($urandom) | 24'h0F0F0F;
            trig_pulse = ($urandom_range(0, 6) == 0);
            hit_ack    = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            tick();
        end
        channel_mask = 24'hFFFFFF;

        // drop counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            trig_pulse = 1'b1;
            tick();
        end
        check("sat_drop_count", 32'(drop_count), 32'd255);
        check("sat_overflow",   32'(overflow),   32'h1);
        hit_ack = 1'b1;
        tick();
        run_to(cyc + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hit_capture.md
Name: hit_capture

Overview:
- Front-end stage that fills the 24-bit data field of the event record.
- Synchronises the 24 comparator outputs and detects rising edges, then accumulates a per-channel hit mask around each accepted trigger.
- Presents the mask with a valid/ack handshake for the record assembler; the record is then shifted out over SPI.
- Runs in the PLL sampling domain alongside the trigger block.

Parameters:
- N_CH, 24, number of comparator channels (data field width).
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2).
- WINDOW, 8, post-trigger collection length in cycles, trigger cycle included (>=2).
- LOOKBACK, 4, pre-trigger edge history depth in cycles (0 = none).

Ports:
- sampling_clk  in  1  block clock (PLL output).
- reset  in  1  asynchronous, active-low reset.
- c_input_async  in  N_CH  raw comparator outputs, active high, asynchronous.
- channel_mask  in  N_CH  1 = channel enabled; quasi-static.
- trig_pulse  in  1  single-cycle trigger strobe, synchronous to sampling_clk.
- hit_data  out  N_CH  latched hit mask.
- hit_valid  out  1  hit_data is valid.
- hit_ack  in  1  consumer has taken hit_data.
- busy  out  1  high in COLLECT or HOLD.
- overflow  out  1  sticky: a trigger was dropped.
- drop_count  out  8  saturating count of dropped triggers.
- hit_mult  out  5  popcount of hit_data (optional feature).

Behaviour:
- Reset values: all outputs 0; synchronisers, history, accumulator and counter cleared; state IDLE. Reset mid-operation aborts any window or held result without emitting it.
- Synchroniser and edge detect:
  - edge[i] = sync[i] & ~prev[i] & channel_mask[i].
  - Input to edge latency is SYNC_STAGES+1 cycles.
  - Levels held high produce one edge only.
- History: shift register of edge vectors, LOOKBACK deep; hist_or = OR of all entries. It updates every cycle in every state.
- States and transitions:
  - IDLE:
    - On trig_pulse in cycle T: acc <= hist_or | edge(T); cnt <= WINDOW-1; go to COLLECT.
    - Otherwise stay.
  - COLLECT:
    - Each cycle: acc |= edge; cnt decrements.
    - The cycle in which edge(T+WINDOW-1) is merged also loads hit_data with the final acc and sets hit_valid.
    - hit_valid first visible in cycle T+WINDOW; go to HOLD.
  - HOLD:
    - hit_data and hit_valid stay stable until hit_ack is sampled high.
    - On hit_ack: hit_valid <= 0, go to IDLE.
- Captured window: edges from cycles T-LOOKBACK through T+WINDOW-1.
- Dropped triggers:
  - trig_pulse in COLLECT, or in HOLD without hit_ack, is dropped.
  - overflow <= 1 (cleared only by reset); drop_count increments, saturating at 255.
- Simultaneous events:
  - hit_ack and trig_pulse in the same HOLD cycle: the trigger is accepted. hit_valid drops, the state goes to COLLECT, the new acc loads as in IDLE, and there is no drop.
  - hit_ack outside HOLD is ignored.
- Empty result: a window with no edges still completes with hit_data = 0 and hit_valid = 1.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro HIT_MULTIPLICITY_EN.
- Defined: hit_mult is loaded with the popcount of the final acc in the same cycle as hit_data, and holds with it.
- Undefined: hit_mult is tied to 0 and no popcount logic is synthesised.

Test Plan:
1. Reset, then c_input_async[3] rises at cycle 0 and trig_pulse at cycle 5 (edge visible at cycle 3, LOOKBACK=4) -> hit_valid at cycle 13, hit_data = 0x000008.
2. trig_pulse at cycle 10, channels 0 and 23 rise so edges appear at cycles 12 and 17, channel 5 edge at cycle 18 -> hit_data = 0x800001; channel 5 is excluded because it falls outside the window. With HIT_MULTIPLICITY_EN, hit_mult = 2.
3. channel_mask = 0xFFFFFE, channel 0 edge inside the window -> hit_data = 0x000000, hit_valid still asserted.
4. Second trig_pulse during COLLECT, then a third during HOLD with hit_ack low -> overflow = 1, drop_count = 2, first result unchanged.
5. In HOLD, hit_ack and trig_pulse in the same cycle -> hit_valid low next cycle, busy stays high, new result valid WINDOW cycles later, drop_count unchanged.
6. Assert reset during COLLECT with edges accumulated -> all outputs 0 immediately; the next trigger yields only post-reset edges.
